// File: rtl/shift_arb_pkg.sv
// Shared types and the combinational shift/rotate function for shift_unit_arbiter.
// Rotates use a doubled operand so the rotate amount never needs a 16-B term.
package shift_arb_pkg;

  typedef enum logic [3:0] {
    SLL = 4'd5,
    SAR = 4'd6,
    ROL = 4'd7,
    ROR = 4'd8
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_e;

  localparam int SHIFT_W = 16;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd8);
  endfunction

  function automatic logic [SHIFT_W-1:0] shift_calc(input logic [SHIFT_W-1:0] a,
                                                    input logic [SHIFT_W-1:0] b,
                                                    input logic [3:0]         op);
    logic [2*SHIFT_W-1:0] dbl;
    logic [SHIFT_W-1:0]   res;
    dbl = {a, a};
    res = '0;
    case (op)
      SLL: res = (b >= 16'd16) ? '0 : (a << b[3:0]);
      SAR: res = (b >= 16'd16) ? {SHIFT_W{a[15]}} : 16'($signed(a) >>> b[3:0]);
      ROL: begin
        dbl = dbl << b[3:0];
        res = dbl[2*SHIFT_W-1:SHIFT_W];
      end
      ROR: begin
        dbl = dbl >> b[3:0];
        res = dbl[SHIFT_W-1:0];
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_rr_arbiter.sv
// Combinational round-robin picker: search starts one past rr_last and wraps.
// The pointer itself is owned by the parent.
module shift_rr_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_last,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (en && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin shared shift/rotate unit with valid/ready on requests and response.
// Optional rsp_err illegal-opcode flag is built when SHIFT_ARB_ILLEGAL_OP_EN is defined.
module shift_unit_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic [ID_W-1:0]       rsp_id
`ifdef SHIFT_ARB_ILLEGAL_OP_EN
  ,
  output logic                  rsp_err
`endif
);

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_last_q;
  logic               arb_en;
  logic               any_grant;

  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [3:0]         sel_op;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [3:0]         op_q;

  // Arbitration only happens when the response slot is free or being drained.
  assign arb_en    = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && rsp_ready));
  assign any_grant = |grant;
  assign req_ready = grant;

  shift_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .rr_last   (rr_last_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_grant ? EXEC : IDLE;
      EXEC:    state_d = HOLD;
      HOLD:    state_d = rsp_ready ? (any_grant ? EXEC : IDLE) : HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= ID_W'(NUM_REQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      state_q <= state_d;
      if (any_grant) begin
        a_q       <= sel_a;
        b_q       <= sel_b;
        op_q      <= sel_op;
        rr_last_q <= grant_idx;
      end
      // rr_last_q still names the winner while EXEC runs
      if (state_q == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_result <= shift_calc(a_q, b_q, op_q);
        rsp_id     <= rr_last_q;
      end else if ((state_q == HOLD) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ARB_ILLEGAL_OP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_err <= !op_legal(op_q);
    end else if ((state_q == HOLD) && rsp_ready) begin
      rsp_err <= 1'b0;
    end
  end
`endif

endmodule
